// File: rtl/bsg_fixed_lat_rx_pkg.sv
// bsg_fixed_lat_rx_pkg: shared widths and error causes for bsg_fixed_lat_rx
package bsg_fixed_lat_rx_pkg;
    typedef enum logic [1:0] {ERR_NONE, ERR_FIFO_OVF, ERR_BAD_LAUNCH, ERR_BAD_YUMI} err_e;
    function automatic int ptr_w(input int els);
        return (els > 1) ? $clog2(els) : 1;
    endfunction
    function automatic int cnt_w(input int els);
        return $clog2(els + 1);
    endfunction
endpackage

// File: rtl/bsg_fixed_lat_rx_mem.sv
// bsg_fixed_lat_rx_mem: els_p x width_p storage, one sync write port, one async read port
module bsg_fixed_lat_rx_mem #(
    parameter int width_p = 27,
    parameter int els_p   = 4,
    parameter int ptr_w_p = 2
) (
    input  logic               clk_i,
    input  logic               w_v_i,
    input  logic [ptr_w_p-1:0] w_addr_i,
    input  logic [width_p-1:0] w_data_i,
    input  logic [ptr_w_p-1:0] r_addr_i,
    output logic [width_p-1:0] r_data_o
);
    logic [width_p-1:0] mem [els_p];
    always_ff @(posedge clk_i)
        if (w_v_i) mem[w_addr_i] <= w_data_i;
    assign r_data_o = mem[r_addr_i];
endmodule

// File: rtl/bsg_fixed_lat_rx.sv
// bsg_fixed_lat_rx: credit-granting receive FIFO for a fixed-latency pipeline.
// Define BSG_FIXED_LAT_RX_BYPASS_EN for a 0-cycle path from data_i to data_o when empty.
module bsg_fixed_lat_rx
    import bsg_fixed_lat_rx_pkg::*;
#(
    parameter int width_p = 27,
    parameter int els_p   = 4,
    parameter int lat_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               launch_v_i,
    output logic               launch_rdy_o,
    input  logic               data_v_i,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i,
    output logic               overflow_o
);
    localparam int pw_lp = ptr_w(els_p);
    localparam int cw_lp = cnt_w(els_p);
    logic [cw_lp-1:0] credit_r, occ_r;
    logic [pw_lp-1:0] wptr_r, rptr_r;
    logic [width_p-1:0] mem_data;
    logic overflow_r, full, empty, launch_ok, yumi_ok, wr, rd, byp;
    err_e err;
    function automatic logic [pw_lp-1:0] nxt(input logic [pw_lp-1:0] p);
        return (p == pw_lp'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction
    assign full         = occ_r == cw_lp'(els_p);
    assign empty        = occ_r == '0;
    assign launch_rdy_o = credit_r != '0;
    assign launch_ok    = launch_v_i & launch_rdy_o;
`ifdef BSG_FIXED_LAT_RX_BYPASS_EN
    assign v_o    = ~empty | data_v_i;
    assign data_o = empty ? data_i : mem_data;
    assign byp    = empty & data_v_i & yumi_i;
`else
    assign v_o    = ~empty;
    assign data_o = mem_data;
    assign byp    = 1'b0;
`endif
    assign yumi_ok    = yumi_i & v_o;
    assign rd         = yumi_ok & ~empty;
    assign wr         = data_v_i & ~byp & (~full | rd);
    assign overflow_o = overflow_r;
    always_comb
        err = (data_v_i & full & ~rd) ? ERR_FIFO_OVF :
              (launch_v_i & ~launch_rdy_o) ? ERR_BAD_LAUNCH :
              (yumi_i & ~v_o) ? ERR_BAD_YUMI : ERR_NONE;
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            credit_r   <= cw_lp'(els_p);
            occ_r      <= '0;
            wptr_r     <= '0;
            rptr_r     <= '0;
            overflow_r <= 1'b0;
        end else begin
            credit_r <= credit_r + cw_lp'(yumi_ok) - cw_lp'(launch_ok);
            occ_r    <= occ_r + cw_lp'(wr) - cw_lp'(rd);
            if (wr) wptr_r <= nxt(wptr_r);
            if (rd) rptr_r <= nxt(rptr_r);
            if (err != ERR_NONE) overflow_r <= 1'b1;
        end
    end
    bsg_fixed_lat_rx_mem #(.width_p(width_p), .els_p(els_p), .ptr_w_p(pw_lp)) mem (
        .clk_i(clk_i), .w_v_i(wr), .w_addr_i(wptr_r), .w_data_i(data_i),
        .r_addr_i(rptr_r), .r_data_o(mem_data)
    );
    // Bad launches are flagged on overflow_o rather than asserted: they are recoverable.
    always_ff @(posedge clk_i)
        if (!reset_i) begin
            assert (err != ERR_FIFO_OVF);
            assert (int'(els_p) - int'(credit_r) - int'(occ_r) <= lat_p + 1);
            assert (!(yumi_i && !v_o));
        end
endmodule

// File: tb/tb_bsg_fixed_lat_rx.sv
// tb_bsg_fixed_lat_rx: scoreboard bench with a lat_p=2 upstream pipeline model
module tb_bsg_fixed_lat_rx;
    logic clk = 0, reset = 1;
    logic launch_v = 0, data_v = 0, yumi = 0, launch_rdy, v_o, overflow;
    logic [26:0] data = '0, data_o, ldata = '0;
    logic lb_v = 0, db_v = 0, yb = 0, rdy_b, vb_o, ovf_b;
    logic [26:0] db = '0, db_o;
    logic pipe_v [2];
    logic [26:0] pipe_d [2];
    logic use_pipe = 1, auto_yumi = 0, acc = 0;
    logic [26:0] q [$];
    logic [26:0] qb [$];
    int checks = 0, errors = 0, cyc_n = 0, first_pop = -1, last_pop = -1, drops = 0, n;

    always #5 clk = ~clk;

    bsg_fixed_lat_rx #(.width_p(27), .els_p(4), .lat_p(2)) dut (
        .clk_i(clk), .reset_i(reset), .launch_v_i(launch_v), .launch_rdy_o(launch_rdy),
        .data_v_i(data_v), .data_i(data), .v_o(v_o), .data_o(data_o), .yumi_i(yumi),
        .overflow_o(overflow)
    );
    bsg_fixed_lat_rx #(.width_p(27), .els_p(3), .lat_p(2)) dut_b (
        .clk_i(clk), .reset_i(reset), .launch_v_i(lb_v), .launch_rdy_o(rdy_b),
        .data_v_i(db_v), .data_i(db), .v_o(vb_o), .data_o(db_o), .yumi_i(yb),
        .overflow_o(ovf_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1; launch_v = 0; data_v = 0; yumi = 0; lb_v = 0; db_v = 0; yb = 0;
        pipe_v[0] = 0; pipe_v[1] = 0; pipe_d[0] = '0; pipe_d[1] = '0;
        q.delete(); qb.delete();
        repeat (2) @(posedge clk);
        #1 reset = 0;
    endtask

    task automatic pre();
        if (use_pipe) begin data_v = pipe_v[1]; data = pipe_d[1]; end
        #1;
        if (auto_yumi) yumi = v_o;
        #1;
        if (v_o && yumi) begin
            if (q.size() == 0) check("sb_nonempty", q.size(), 1);
            else begin
                if (first_pop < 0) first_pop = cyc_n;
                last_pop = cyc_n;
                check("data", data_o, q.pop_front());
            end
        end
        if (launch_v && !launch_rdy) drops++;
        acc = launch_v && launch_rdy;
        if (acc) q.push_back(ldata);
    endtask

    task automatic post();
        @(posedge clk);
        #1;
        pipe_v[1] = pipe_v[0]; pipe_d[1] = pipe_d[0];
        pipe_v[0] = acc;       pipe_d[0] = ldata;
        cyc_n++;
    endtask

    task automatic cyc();
        pre();
        post();
    endtask

    task automatic drain();
        auto_yumi = 1; launch_v = 0; n = 0;
        while ((q.size() > 0 || pipe_v[0] || pipe_v[1]) && n < 20) begin cyc(); n++; end
        check("drain_empty", q.size(), 0);
        auto_yumi = 0; yumi = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // reset
        do_reset();
        check("rst_rdy", launch_rdy, 1);
        check("rst_v", v_o, 0);
        check("rst_ovf", overflow, 0);
        check("rst_credit", dut.credit_r, 4);
        // streaming
        auto_yumi = 1; drops = 0; first_pop = -1;
        for (int i = 0; i < 100; i++) begin
            launch_v = 1; ldata = 27'(i * 7 + 3);
            cyc();
        end
        drain();
        check("stream_drops", drops, 0);
        check("stream_span", last_pop - first_pop, 99);
        check("stream_ovf", overflow, 0);
        check("stream_credit", dut.credit_r, 4);
        // stall until credits run out
        do_reset();
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (!launch_rdy) break;
            launch_v = 1; ldata = 27'(16'h100 + i);
            cyc(); n++;
        end
        launch_v = 0;
        check("stall_launches", n, 4);
        cyc(); cyc();
        check("stall_occ", dut.occ_r, 4);
        check("stall_v", v_o, 1);
        check("stall_ovf_before", overflow, 0);
        launch_v = 1; ldata = 27'h3FF;
        cyc();
        launch_v = 0;
        check("bad_launch_ovf", overflow, 1);
        check("bad_launch_credit", dut.credit_r, 0);
        check("bad_launch_q", q.size(), 4);
        drain();
        // simultaneous write and yumi with one entry
        do_reset();
        launch_v = 1; ldata = 27'h1A5; cyc();
        ldata = 27'h2B6; cyc();
        launch_v = 0; cyc();
        check("sim_credit_before", dut.credit_r, 2);
        yumi = 1; cyc(); yumi = 0;
        check("sim_v", v_o, 1);
        check("sim_data", data_o, 27'h2B6);
        check("sim_occ", dut.occ_r, 1);
        check("sim_credit_after", dut.credit_r, 3);
        drain();
        // wrap on the 3-deep instance
        do_reset();
        for (int i = 0; i <= 10; i++) begin
            lb_v = (i < 10); db_v = (i < 10); db = 27'(i);
            if (i < 10) begin
                check("wrap_rdy", rdy_b, 1);
                qb.push_back(27'(i));
            end
            #1;
            yb = (i > 0) && vb_o;
            #1;
            if (yb) check("wrap_data", db_o, qb.pop_front());
            @(posedge clk);
            #1;
        end
        lb_v = 0; db_v = 0; yb = 0;
        check("wrap_wptr", dut_b.wptr_r, 1);
        check("wrap_rptr", dut_b.rptr_r, 1);
        check("wrap_q", qb.size(), 0);
        check("wrap_ovf", ovf_b, 0);
        // empty-FIFO arrival with the consumer ready
        do_reset();
        launch_v = 1; ldata = 27'h7; cyc();
        launch_v = 0; cyc();
`ifdef BSG_FIXED_LAT_RX_BYPASS_EN
        yumi = 1;
        pre();
        check("byp_v", v_o, 1);
        check("byp_data", data_o, 27'h7);
        post();
        yumi = 0;
        check("byp_v_after", v_o, 0);
        check("byp_occ", dut.occ_r, 0);
        check("byp_credit", dut.credit_r, 4);
`else
        pre();
        check("nobyp_v", v_o, 0);
        post();
        check("nobyp_v_next", v_o, 1);
        check("nobyp_data_next", data_o, 27'h7);
        yumi = 1; cyc(); yumi = 0;
        check("nobyp_credit", dut.credit_r, 4);
`endif
        check("final_q", q.size(), 0);
        check("final_ovf", overflow, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
